// File: rtl/io_device_responder.sv
// Device side of the keyboard/display status handshake: a keystroke FIFO feeding
// the KBDR/KBSR pair and a delayed character emitter driven from the DDR/DSR pair.
module io_device_responder #(
  parameter int KBD_DEPTH = 4,
  parameter int DSP_DELAY = 3
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_Key_Valid,
  input  logic [7:0]  i_Key_Data,
  output logic        o_Key_Ready,
  input  logic [15:0] KBSR_OUT,
  output logic [15:0] o_INPUT_KBDR,
  output logic [15:0] o_INPUT_KBSR,
  input  logic [15:0] DSR_OUT,
  input  logic [15:0] DDR_OUT,
  output logic [15:0] o_OUTPUT_DSR,
  output logic        o_Char_Valid,
  output logic [7:0]  o_Char_Data
);

  localparam int AW = (KBD_DEPTH > 1) ? $clog2(KBD_DEPTH) : 1;
  localparam int CW = $clog2(DSP_DELAY + 1);
  localparam logic [AW:0]   DEPTH_C    = (AW + 1)'(KBD_DEPTH);
  localparam logic [AW:0]   CNT_ZERO_C = {(AW + 1){1'b0}};
  localparam logic [AW:0]   CNT_ONE_C  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE_C  = {{(AW - 1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] DLY_LOAD_C = CW'(DSP_DELAY - 1);
  localparam logic [CW-1:0] DLY_ZERO_C = {CW{1'b0}};
  localparam logic [CW-1:0] DLY_ONE_C  = {{(CW - 1){1'b0}}, 1'b1};
  localparam logic [15:0]   REQ_C      = 16'h0001;
  localparam logic [15:0]   DONE_C     = 16'h0002;

  typedef enum logic [1:0] {
    K_IDLE = 2'd0,
    K_LOAD = 2'd1,
    K_DONE = 2'd2
  } kbd_state_t;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_BUSY = 2'd1,
    D_EMIT = 2'd2,
    D_DONE = 2'd3
  } dsp_state_t;

  logic [7:0]    r_fifo_mem [KBD_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_count_nxt;
  logic          r_key_ready;
  logic          w_push;
  logic          w_pop;

  kbd_state_t    r_kbd_state;
  logic [15:0]   r_kbdr;
  logic [15:0]   r_kbsr;

  dsp_state_t    r_dsp_state;
  logic [CW-1:0] r_dly_cnt;
  logic [15:0]   r_dsr;
  logic          r_char_valid;
  logic [7:0]    r_char_data;
  logic          w_unused_ddr_hi;

  assign w_unused_ddr_hi = ^DDR_OUT[15:8];

  // Ready is registered from the full flag, so a push while full is dropped even when a pop frees a slot.
  assign w_push = i_Key_Valid & r_key_ready;
  assign w_pop  = (r_kbd_state == K_IDLE) & (KBSR_OUT == REQ_C) & (r_count != CNT_ZERO_C);

  // Next FIFO occupancy from this cycle's push/pop pair
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_ONE_C;
      2'b01:   w_count_nxt = r_count - CNT_ONE_C;
      default: w_count_nxt = r_count;
    endcase
  end

  // FIFO pointers, occupancy and registered ready flag
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_wr_ptr    <= {AW{1'b0}};
      r_rd_ptr    <= {AW{1'b0}};
      r_count     <= CNT_ZERO_C;
      r_key_ready <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE_C;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE_C;
      r_count     <= w_count_nxt;
      r_key_ready <= (w_count_nxt != DEPTH_C);
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge i_Clk) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= i_Key_Data;
  end

  // Keyboard handshake: data lands one state ahead of the status word
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_kbd_state <= K_IDLE;
      r_kbdr      <= 16'h0000;
      r_kbsr      <= 16'h0000;
    end else begin
      case (r_kbd_state)
        K_IDLE: begin
          r_kbsr <= 16'h0000;
          if (w_pop) begin
            r_kbdr      <= {8'h00, r_fifo_mem[r_rd_ptr]};
            r_kbd_state <= K_LOAD;
          end
        end
        K_LOAD: begin
          r_kbsr      <= 16'h0000;
          r_kbd_state <= K_DONE;
        end
        K_DONE: begin
          if (KBSR_OUT != REQ_C) begin
            r_kbsr      <= 16'h0000;
            r_kbd_state <= K_IDLE;
          end else begin
            r_kbsr <= DONE_C;
          end
        end
        default: begin
          r_kbsr      <= 16'h0000;
          r_kbd_state <= K_IDLE;
        end
      endcase
    end
  end

  // Display handshake: capture, count down, strobe once, then report done
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_dsp_state  <= D_IDLE;
      r_dly_cnt    <= DLY_ZERO_C;
      r_dsr        <= 16'h0000;
      r_char_valid <= 1'b0;
      r_char_data  <= 8'h00;
    end else begin
      case (r_dsp_state)
        D_IDLE: begin
          r_dsr        <= 16'h0000;
          r_char_valid <= 1'b0;
          if (DSR_OUT == REQ_C) begin
            r_char_data <= DDR_OUT[7:0];
            r_dly_cnt   <= DLY_LOAD_C;
            r_dsp_state <= D_BUSY;
          end
        end
        D_BUSY: begin
          r_char_valid <= 1'b0;
          if (r_dly_cnt == DLY_ZERO_C) begin
            r_dsp_state <= D_EMIT;
          end else begin
            r_dly_cnt <= r_dly_cnt - DLY_ONE_C;
          end
        end
        D_EMIT: begin
          r_char_valid <= 1'b1;
          r_dsp_state  <= D_DONE;
        end
        D_DONE: begin
          r_char_valid <= 1'b0;
          if (DSR_OUT != REQ_C) begin
            r_dsr       <= 16'h0000;
            r_dsp_state <= D_IDLE;
          end else begin
            r_dsr <= DONE_C;
          end
        end
        default: begin
          r_char_valid <= 1'b0;
          r_dsr        <= 16'h0000;
          r_dsp_state  <= D_IDLE;
        end
      endcase
    end
  end

  assign o_Key_Ready  = r_key_ready;
  assign o_INPUT_KBDR = r_kbdr;
  assign o_INPUT_KBSR = r_kbsr;
  assign o_OUTPUT_DSR = r_dsr;
  assign o_Char_Valid = r_char_valid;
  assign o_Char_Data  = r_char_data;

endmodule

// File: tb/tb_io_device_responder.sv
// Scoreboard bench for io_device_responder: expected keys/characters are queued
// when driven and compared when the device completes each handshake.
module tb_io_device_responder;

  localparam int KBD_DEPTH = 4;
  localparam int DSP_DELAY = 3;

  typedef struct {
    logic [7:0] data;
    int         due;
  } dexp_t;

  logic        clk;
  logic        rst_n;
  logic        key_valid;
  logic [7:0]  key_data;
  logic        key_ready;
  logic [15:0] kbsr_out;
  logic [15:0] kbdr_in;
  logic [15:0] kbsr_in;
  logic [15:0] dsr_out;
  logic [15:0] ddr_out;
  logic [15:0] dsr_in;
  logic        char_valid;
  logic [7:0]  char_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_pulses = 0;
  int last_kbd_cyc = -1;
  int last_dsr_cyc = -1;
  int t0;

  logic [7:0] kq[$];
  dexp_t      dq[$];

  logic [15:0] prev_kbsr  = 16'h0000;
  logic [15:0] prev_kbdr  = 16'h0000;
  logic [15:0] prev_dsr   = 16'h0000;
  logic        prev_valid = 1'b0;

  io_device_responder #(.KBD_DEPTH(KBD_DEPTH), .DSP_DELAY(DSP_DELAY)) dut (
    .i_Clk        (clk),
    .i_Rst_n      (rst_n),
    .i_Key_Valid  (key_valid),
    .i_Key_Data   (key_data),
    .o_Key_Ready  (key_ready),
    .KBSR_OUT     (kbsr_out),
    .o_INPUT_KBDR (kbdr_in),
    .o_INPUT_KBSR (kbsr_in),
    .DSR_OUT      (dsr_out),
    .DDR_OUT      (ddr_out),
    .o_OUTPUT_DSR (dsr_in),
    .o_Char_Valid (char_valid),
    .o_Char_Data  (char_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: pops expectations when a handshake completes
  always @(negedge clk) begin
    dexp_t e;
    logic [7:0] k;
    if (rst_n) begin
      if (kbsr_in == 16'h0002 && prev_kbsr == 16'h0000) begin
        last_kbd_cyc = cyc;
        if (kq.size() == 0) begin
          check("kbd_spurious", 32'd1, 32'd0);
        end else begin
          k = kq.pop_front();
          check("kbdr_data", 32'(kbdr_in), {24'h0, k});
          check("kbdr_setup", 32'(prev_kbdr), {24'h0, k});
        end
      end
      if (kbsr_in != 16'h0000 && kbsr_in != 16'h0002)
        check("kbsr_value", 32'(kbsr_in), 32'd2);
      if (char_valid) begin
        n_pulses++;
        if (prev_valid) check("strobe_width", 32'd2, 32'd1);
        if (dq.size() == 0) begin
          check("dsp_spurious", 32'd1, 32'd0);
        end else begin
          e = dq.pop_front();
          check("char_data", 32'(char_data), {24'h0, e.data});
          check("char_latency", 32'(cyc), 32'(e.due));
        end
      end
      if (dsr_in == 16'h0002 && prev_dsr == 16'h0000) last_dsr_cyc = cyc;
    end
    prev_kbsr  = kbsr_in;
    prev_kbdr  = kbdr_in;
    prev_dsr   = dsr_in;
    prev_valid = char_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_key(input logic [7:0] k);
    key_valid = 1'b1;
    key_data  = k;
    step();
    key_valid = 1'b0;
  endtask

  task automatic wait_kbsr(input logic [15:0] v, input string tag);
    int n = 0;
    while (kbsr_in !== v && n < 30) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(kbsr_in), 32'(v));
  endtask

  task automatic wait_dsr(input logic [15:0] v, input string tag);
    int n = 0;
    while (dsr_in !== v && n < 30) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(dsr_in), 32'(v));
  endtask

  task automatic kbd_handshake(input string tag);
    kbsr_out = 16'h0001;
    wait_kbsr(16'h0002, tag);
    step();
    kbsr_out = 16'h0002;
    step();
    check("kbsr_release", 32'(kbsr_in), 32'd0);
    kbsr_out = 16'h0000;
  endtask

  task automatic check_outputs_reset(input string tag);
    check({tag, "_kbdr"},  32'(kbdr_in),    32'd0);
    check({tag, "_kbsr"},  32'(kbsr_in),    32'd0);
    check({tag, "_dsr"},   32'(dsr_in),     32'd0);
    check({tag, "_valid"}, 32'(char_valid), 32'd0);
    check({tag, "_cdata"}, 32'(char_data),  32'd0);
    check({tag, "_ready"}, 32'(key_ready),  32'd1);
  endtask

  initial begin
    rst_n = 1'b0; key_valid = 1'b0; key_data = 8'h00;
    kbsr_out = 16'h0000; dsr_out = 16'h0000; ddr_out = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_reset("rst");
    rst_n = 1'b1;
    step();
    check_outputs_reset("post_rst");

    // 1: key present before the request
    kq.push_back(8'h41);
    push_key(8'h41);
    step();
    t0 = cyc;
    kbsr_out = 16'h0001;
    wait_kbsr(16'h0002, "t1_done");
    step();
    check("t1_latency", 32'(last_kbd_cyc), 32'(t0 + 3));
    kbsr_out = 16'h0002;
    step();
    check("t1_clear", 32'(kbsr_in), 32'd0);
    kbsr_out = 16'h0000;
    step();

    // 2: request pending on an empty FIFO
    kbsr_out = 16'h0001;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t2_pending", 32'(kbsr_in), 32'd0);
    end
    step();
    t0 = cyc;
    kq.push_back(8'h5A);
    push_key(8'h5A);
    wait_kbsr(16'h0002, "t2_done");
    step();
    check("t2_latency", 32'(last_kbd_cyc), 32'(t0 + 4));
    kbsr_out = 16'h0002;
    step();
    check("t2_clear", 32'(kbsr_in), 32'd0);
    kbsr_out = 16'h0000;
    step();

    // 3: overfill, drain in order across the pointer wrap
    for (int i = 1; i <= 5; i++) begin
      key_valid = 1'b1;
      key_data  = 8'(i);
      if (i <= KBD_DEPTH) kq.push_back(8'(i));
      step();
      if (i == KBD_DEPTH) check("t3_full", 32'(key_ready), 32'd0);
    end
    key_valid = 1'b0;
    step();
    check("t3_still_full", 32'(key_ready), 32'd0);
    for (int i = 0; i < KBD_DEPTH; i++) kbd_handshake("t3_done");
    check("t3_ready", 32'(key_ready), 32'd1);
    kbsr_out = 16'h0001;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t3_dropped", 32'(kbsr_in), 32'd0);
    end
    step();
    kbsr_out = 16'h0000;
    step();

    // 4: display request, DDR changes while busy are ignored
    t0 = cyc;
    ddr_out = 16'h1263;
    dsr_out = 16'h0001;
    dq.push_back('{data: 8'h63, due: t0 + DSP_DELAY + 2});
    step();
    ddr_out = 16'hFFAA;
    wait_dsr(16'h0002, "t4_done");
    step();
    check("t4_dsr_latency", 32'(last_dsr_cyc), 32'(t0 + DSP_DELAY + 3));
    dsr_out = 16'h0002;
    step();
    check("t4_clear", 32'(dsr_in), 32'd0);
    dsr_out = 16'h0000;
    step();

    // 5: keyboard and display requests in the same cycle
    kq.push_back(8'h33);
    push_key(8'h33);
    t0 = cyc;
    kbsr_out = 16'h0001;
    dsr_out  = 16'h0001;
    ddr_out  = 16'h0077;
    dq.push_back('{data: 8'h77, due: t0 + DSP_DELAY + 2});
    wait_dsr(16'h0002, "t5_dsr_done");
    step();
    check("t5_kbd_latency", 32'(last_kbd_cyc), 32'(t0 + 3));
    check("t5_dsr_latency", 32'(last_dsr_cyc), 32'(t0 + DSP_DELAY + 3));
    check("t5_kbsr_held", 32'(kbsr_in), 32'd2);
    kbsr_out = 16'h0002;
    dsr_out  = 16'h0002;
    step();
    check("t5_kbsr_clear", 32'(kbsr_in), 32'd0);
    check("t5_dsr_clear", 32'(dsr_in), 32'd0);
    kbsr_out = 16'h0000;
    dsr_out  = 16'h0000;
    step();

    // 6: reset during the display countdown with two keys buffered
    push_key(8'h88);
    push_key(8'h99);
    ddr_out = 16'h0055;
    dsr_out = 16'h0001;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check_outputs_reset("t6_rst");
    dsr_out = 16'h0000;
    step();
    step();
    rst_n = 1'b1;
    step();
    kbsr_out = 16'h0001;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t6_fifo_empty", 32'(kbsr_in), 32'd0);
    end
    step();
    kq.push_back(8'h11);
    push_key(8'h11);
    wait_kbsr(16'h0002, "t6_done");
    step();
    kbsr_out = 16'h0002;
    step();
    check("t6_clear", 32'(kbsr_in), 32'd0);
    kbsr_out = 16'h0000;
    repeat (DSP_DELAY + 4) step();

    check("kbd_queue_empty", 32'(kq.size()), 32'd0);
    check("dsp_queue_empty", 32'(dq.size()), 32'd0);
    check("strobe_count", 32'(n_pulses), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
